// File: rtl/image_stride_ctrl.sv
// image_stride_ctrl: row-burst sequencer for the image stride FIFO (stride-1 passthrough / stride-2 decimation).
// Define IMAGE_STRIDE_PERF_EN to add the stall_cnt / row_cnt performance counter ports.
module image_stride_ctrl #(
    parameter int WIDTH     = 256,
    parameter int ADDR_BITS = 10,
    parameter int ROW_BITS  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stride2,
    input  logic [ADDR_BITS:0]   col_num,
    input  logic [ROW_BITS-1:0]  row_num,
    output logic [ADDR_BITS:0]   M_count,
    input  logic                 M_Ready,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic [ADDR_BITS:0]   S_count,
    input  logic                 S_Ready,
    output logic                 dout_vld,
    output logic [WIDTH-1:0]     dout,
    output logic                 busy,
    output logic                 done
`ifdef IMAGE_STRIDE_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [ROW_BITS-1:0]  row_cnt
`endif
);
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_READ, ST_SETTLE, ST_DRAIN, ST_DONE} state_t;
    state_t state, state_nx;
    logic                 cfg_s2, settle;
    logic [ADDR_BITS:0]   cfg_col, col;
    logic [ROW_BITS-1:0]  cfg_row, row;
    logic [ADDR_BITS+1:0] half_col;
    logic                 accept, go, last_col, last_row, keep;
    assign accept   = state == ST_IDLE && start;
    assign go       = M_Ready && S_Ready;
    assign last_col = col == cfg_col - 1'b1;
    assign last_row = row == cfg_row - 1'b1;
    assign keep     = !cfg_s2 || (!row[0] && !col[0]);
    assign half_col = ({1'b0, cfg_col} + (ADDR_BITS+2)'(1)) >> 1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end
    // Empty frames skip straight to the drain/done tail so done still pulses once.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = !start ? ST_IDLE : (col_num == '0 || row_num == '0) ? ST_DRAIN : ST_WAIT;
            ST_WAIT:   state_nx = go ? ST_READ : ST_WAIT;
            ST_READ:   state_nx = !last_col ? ST_READ : last_row ? ST_DRAIN : ST_SETTLE;
            ST_SETTLE: state_nx = settle ? ST_WAIT : ST_SETTLE;
            ST_DRAIN:  state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end
    always_comb begin
        fifo_rd_en = state == ST_READ;
        busy       = state != ST_IDLE && state != ST_DONE;
        done       = state == ST_DONE;
        M_count    = cfg_col;
        S_count    = !cfg_s2 ? cfg_col : row[0] ? '0 : half_col[ADDR_BITS:0];
        dout       = dout_vld ? fifo_dout : '0;
    end
    // dout_vld lines up with the FIFO's one-cycle read latency; dout is the FIFO output gated by it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_vld <= 1'b0;
            settle   <= 1'b0;
            cfg_s2   <= 1'b0;
            cfg_col  <= '0;
            cfg_row  <= '0;
            col      <= '0;
            row      <= '0;
        end else begin
            dout_vld <= fifo_rd_en && keep;
            settle   <= state == ST_SETTLE && !settle;
            if (accept) begin
                cfg_s2  <= stride2;
                cfg_col <= col_num;
                cfg_row <= row_num;
                col     <= '0;
                row     <= '0;
            end else if (state == ST_READ) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col && !last_row) row <= row + 1'b1;
            end
        end
    end
`ifdef IMAGE_STRIDE_PERF_EN
    // Stalls count only WAIT cycles that could not launch a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            row_cnt   <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
            row_cnt   <= '0;
        end else begin
            if (state == ST_WAIT && !go && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (state == ST_READ && last_col && row_cnt != '1) row_cnt <= row_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_image_stride_ctrl.sv
// tb_image_stride_ctrl: directed frame vectors plus hand-written stall/reset/restart sequences.
module tb_image_stride_ctrl;
    localparam int WIDTH = 256;
    localparam int AB    = 10;
    localparam int RB    = 10;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, stride2 = 1'b0;
    logic              M_Ready = 1'b1, S_Ready = 1'b1;
    logic [AB:0]       col_num = '0;
    logic [RB-1:0]     row_num = '0;
    logic [AB:0]       M_count, S_count;
    logic              fifo_rd_en, dout_vld, busy, done;
    logic [WIDTH-1:0]  fifo_dout = '0, dout;
`ifdef IMAGE_STRIDE_PERF_EN
    logic [31:0]       stall_cnt;
    logic [RB-1:0]     row_cnt;
`endif

    image_stride_ctrl #(.WIDTH(WIDTH), .ADDR_BITS(AB), .ROW_BITS(RB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stride2(stride2),
        .col_num(col_num), .row_num(row_num), .M_count(M_count), .M_Ready(M_Ready),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .S_count(S_count), .S_Ready(S_Ready),
        .dout_vld(dout_vld), .dout(dout), .busy(busy), .done(done)
`ifdef IMAGE_STRIDE_PERF_EN
        , .stall_cnt(stall_cnt), .row_cnt(row_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Source FIFO model: each read returns its running index, one cycle later.
    logic [31:0] rd_idx = '0;
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= {8{rd_idx}};
            rd_idx    <= rd_idx + 1;
        end
    end

    int rd_seen = 0, done_seen = 0, viol = 0, m_seen = -1;
    logic prev_rd = 1'b0;
    logic [WIDTH-1:0] got_q[$];
    int s_q[$];
    always @(negedge clk) begin
        if (fifo_rd_en) rd_seen++;
        if (fifo_rd_en && !busy) viol++;
        if (fifo_rd_en && !prev_rd) begin
            s_q.push_back(int'(S_count));
            m_seen = int'(M_count);
        end
        if (dout_vld) got_q.push_back(dout);
        if (done) done_seen++;
        prev_rd = fifo_rd_en;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic s2;
        int   col;
        int   row;
        int   reads;
        int   words;
        int   s0;
        int   s1;
    } vec_t;

    logic [31:0] base;

    task automatic kick(input logic s2, input int col, input int row);
        @(negedge clk);
        rd_seen = 0; done_seen = 0; m_seen = -1;
        got_q.delete(); s_q.delete();
        base = rd_idx;
        start = 1'b1; stride2 = s2;
        col_num = (AB+1)'(col); row_num = RB'(row);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish(input string name, input vec_t v);
        int cyc = 0;
        int bad = 0;
        logic [WIDTH-1:0] exp_q[$];
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_done_in_time"}, longint'(cyc < 2000), 1);
        if (v.reads == 0) check({name, "_empty_latency_le3"}, longint'(cyc <= 3), 1);
        repeat (2) @(negedge clk);
        check({name, "_reads"}, rd_seen, v.reads);
        check({name, "_words"}, got_q.size(), v.words);
        check({name, "_done_pulses"}, done_seen, 1);
        check({name, "_busy_after"}, busy, 0);
        for (int r = 0; r < v.row; r++)
            for (int c = 0; c < v.col; c++)
                if (!v.s2 || (r % 2 == 0 && c % 2 == 0))
                    exp_q.push_back({8{base + 32'(r * v.col + c)}});
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check({name, "_data_bad_words"}, bad, 0);
        check({name, "_rows_started"}, s_q.size(), v.col > 0 ? v.row : 0);
        if (s_q.size() > 0) check({name, "_s_count_row0"}, s_q[0], v.s0);
        if (s_q.size() > 1) check({name, "_s_count_row1"}, s_q[1], v.s1);
        if (v.reads > 0) check({name, "_m_count"}, m_seen, v.col);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b0, 4, 2,  8, 8, 4, 4};
        vecs[1] = '{1'b1, 5, 3, 15, 6, 3, 0};
        vecs[2] = '{1'b0, 1, 1,  1, 1, 1, 0};
        vecs[3] = '{1'b1, 4, 2,  8, 2, 2, 0};
        vecs[4] = '{1'b1, 1, 4,  4, 2, 1, 0};
        vecs[5] = '{1'b1, 6, 2, 12, 3, 3, 0};
        vecs[6] = '{1'b0, 0, 3,  0, 0, 0, 0};
        vecs[7] = '{1'b1, 3, 0,  0, 0, 0, 0};
        vecs[8] = '{1'b1, 2, 1,  2, 1, 1, 0};

        repeat (3) @(negedge clk);
        check("reset_rd_en", fifo_rd_en, 0);
        check("reset_dout_vld", dout_vld, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_m_count", M_count, 0);
        check("reset_s_count", S_count, 0);
        check("reset_dout", longint'(dout != '0), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            kick(vecs[i].s2, vecs[i].col, vecs[i].row);
            finish($sformatf("vec%0d", i), vecs[i]);
        end

        // M_Ready held low: no reads for 20 cycles, READ the cycle after it rises
        M_Ready = 1'b0;
        kick(1'b0, 3, 1);
        repeat (20) @(negedge clk);
        check("mstall_no_reads", rd_seen, 0);
        check("mstall_busy", busy, 1);
        M_Ready = 1'b1;
        @(negedge clk);
        check("mstall_read_next", fifo_rd_en, 1);
        finish("mstall", '{1'b0, 3, 1, 3, 3, 3, 0});
`ifdef IMAGE_STRIDE_PERF_EN
        check("mstall_stall_cnt", stall_cnt, 20);
        check("mstall_row_cnt", row_cnt, 1);
`endif

        // S_Ready low with M_Ready high: stays in WAIT, no reads
        S_Ready = 1'b0;
        kick(1'b1, 4, 2);
        repeat (10) @(negedge clk);
        check("sstall_no_reads", rd_seen, 0);
        check("sstall_no_rd_en", fifo_rd_en, 0);
        S_Ready = 1'b1;
        finish("sstall", '{1'b1, 4, 2, 8, 2, 2, 0});

        // Reset during READ of column 2, then a clean restart
        begin
            int n = 0;
            int cyc = 0;
            kick(1'b0, 6, 2);
            while (n < 3 && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (fifo_rd_en) n++;
            end
            check("midrst_reached_col2", n, 3);
            check("midrst_vld_before", dout_vld, 1);
            rst_n = 1'b0;
            #1;
            check("midrst_rd_en", fifo_rd_en, 0);
            check("midrst_busy", busy, 0);
            check("midrst_dout_vld", dout_vld, 0);
            @(negedge clk);
            check("midrst_still_idle", fifo_rd_en, 0);
            rst_n = 1'b1;
        end
        kick(1'b0, 4, 2);
        finish("restart", vecs[0]);

        // Second start and cfg changes mid-frame must be ignored
        M_Ready = 1'b0;
        kick(1'b0, 2, 2);
        repeat (3) @(negedge clk);
        start = 1'b1; stride2 = 1'b1; col_num = 7; row_num = 5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        M_Ready = 1'b1;
        finish("busystart", '{1'b0, 2, 2, 4, 4, 2, 2});

        check("rd_outside_busy", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
